// File: rtl/ds_dac_mod.sv
// rtl/ds_dac_mod.sv - 1-bit delta-sigma DAC modulator, run-time 1st/2nd order, OSR sample handshake
// Sticky underrun/overflow flags; overflow resets the error history so the loop recovers.
module ds_dac_mod #(
  parameter int W   = 16,
  parameter int OSR = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_en,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         order_sel,
  input  logic         clr_flags,
  output logic         ce_out,
  output logic         dout,
  output logic         underrun,
  output logic         ovf
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(OSR - 1);
  localparam int QI = 1 << (W - 1);
  localparam logic signed [W+1:0] Q_E  = (W+2)'(QI);
  localparam logic signed [W+2:0] Q3_V = (W+3)'(3 * QI);

  logic [CW-1:0]         cnt;
  logic signed [W-1:0]   u;
  logic signed [W+1:0]   e1;
  logic signed [W+1:0]   e2;
  logic                  mode;

  logic signed [W+2:0]   u_x;
  logic signed [W+2:0]   e1_x;
  logic signed [W+2:0]   e2_x;
  logic signed [W+2:0]   v;
  logic signed [W+1:0]   y;
  logic signed [W+1:0]   e;
  logic                  pos;
  logic                  ovf_hit;
  logic                  miss;

  assign ce_out    = clk_en;
  assign din_ready = (cnt == CNT_MAX) & clk_en;
  assign miss      = din_ready & ~din_valid;

  assign u_x  = {{3{u[W-1]}}, u};
  assign e1_x = {e1[W+1], e1};
  assign e2_x = {e2[W+1], e2};

  // Second order wraps modulo 2^(W+3) in the intermediate sum; the final v is still exact.
  always_comb begin
    v = u_x + e1_x;
    if (mode) begin
      v = u_x + (e1_x <<< 1) - e2_x;
    end
  end

  assign pos     = ~v[W+2];
  assign y       = pos ? Q_E : -Q_E;
  assign e       = v[W+1:0] - y;
  assign ovf_hit = (v >= Q3_V) || (v <= -Q3_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      u    <= '0;
      e1   <= '0;
      e2   <= '0;
      mode <= 1'b0;
      dout <= 1'b0;
    end else if (clk_en) begin
      cnt  <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      dout <= pos;
      if (ovf_hit) begin
        e1 <= '0;
        e2 <= '0;
      end else begin
        e1 <= e;
        e2 <= e1;
      end
      if (din_ready && din_valid) begin
        u    <= {~din[W-1], din[W-2:0]};
        mode <= order_sel;
      end
    end
  end

  // Set events override a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (clr_flags) begin
        underrun <= 1'b0;
        ovf      <= 1'b0;
      end
      if (miss) begin
        underrun <= 1'b1;
      end
      if (clk_en && ovf_hit) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ds_dac_mod.sv
// tb/tb_ds_dac_mod.sv - directed self-checking bench for ds_dac_mod (W=16, OSR=4)
module tb_ds_dac_mod;

  localparam int W   = 16;
  localparam int OSR = 4;

  logic         clk;
  logic         rst_n;
  logic         clk_en;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready;
  logic         order_sel;
  logic         clr_flags;
  logic         ce_out;
  logic         dout;
  logic         underrun;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  ds_dac_mod #(.W(W), .OSR(OSR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .order_sel (order_sel),
    .clr_flags (clr_flags),
    .ce_out    (ce_out),
    .dout      (dout),
    .underrun  (underrun),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    clr_flags = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 4 * OSR; k++) begin
      #1;
      if (din_ready === 1'b1) break;
      cyc();
    end
    check("wait_ready", {31'd0, din_ready}, 32'd1);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (dout === 1'b1) ones++;
    end
  endtask

  int ones;
  int bad;
  int bad_rdy;
  logic [1:0] c_hold;
  logic       d_hold;

  initial begin
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    din       = '0;
    din_valid = 1'b1;
    order_sel = 1'b0;
    clr_flags = 1'b0;

    // Reset with random input activity
    for (int i = 0; i < 5; i++) begin
      din = W'($urandom);
      cyc();
      check("rst_dout", {31'd0, dout}, 32'd0);
      check("rst_din_ready", {31'd0, din_ready}, 32'd0);
      check("rst_flags", {30'd0, underrun, ovf}, 32'd0);
    end
    check("rst_ce_out_hi", {31'd0, ce_out}, 32'd1);
    clk_en = 1'b0;
    #1;
    check("rst_ce_out_lo", {31'd0, ce_out}, 32'd0);

    // Release: din_ready on enabled cycles 4, 8, 12
    din    = 16'h8000;
    clk_en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      #1;
      check($sformatf("ready_c%0d", i), {31'd0, din_ready}, (i % 4 == 0) ? 32'd1 : 32'd0);
      cyc();
    end

    // Midscale, order 0: toggling 1,0,1,0 after capture
    do_reset();
    din = 16'h8000; order_sel = 1'b0; din_valid = 1'b1;
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("mid_t%0d", i), {31'd0, dout}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Near full scale, order 0: no zero for 1024 cycles after capture
    do_reset();
    din = 16'hFFFF;
    repeat (4) cyc();
    count_ones(1024, ones);
    check("ffff_ones", ones, 32'd1024);
    check("ffff_ovf", {31'd0, ovf}, 32'd0);

    // Zero scale, order 0 then order 1
    do_reset();
    din = 16'h0000; order_sel = 1'b0;
    repeat (4) cyc();
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (dout !== 1'b0) bad++;
      cyc();
    end
    check("zero_o0_dout", bad, 32'd0);
    order_sel = 1'b1;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (dout !== 1'b0) bad++;
      cyc();
    end
    check("zero_o1_dout", bad, 32'd0);
    check("zero_o1_mode", {31'd0, dut.mode}, 32'd1);
    check("zero_ovf", {31'd0, ovf}, 32'd0);

    // 0.75 scale, order 1
    din = 16'hC000;
    wait_ready();
    cyc();
    repeat (8) cyc();
    count_ones(1024, ones);
    check("c000_ones_768pm2", {31'd0, (ones >= 766 && ones <= 770)}, 32'd1);
    check("c000_ovf", {31'd0, ovf}, 32'd0);

    // Order change between captures does nothing
    wait_ready();
    cyc();
    order_sel = 1'b0;
    cyc();
    cyc();
    check("order_hold", {31'd0, dut.mode}, 32'd1);
    order_sel = 1'b1;

    // clk_en at 50%: frozen when low, no din_ready when low
    bad = 0; bad_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      clk_en = i[0];
      #1;
      c_hold = dut.cnt;
      d_hold = dout;
      if (!clk_en && (din_ready !== 1'b0 || ce_out !== 1'b0)) bad_rdy++;
      cyc();
      if (!clk_en && (dut.cnt !== c_hold || dout !== d_hold)) bad++;
      if (clk_en && dut.cnt === c_hold) bad++;
    end
    clk_en = 1'b1;
    check("gap_frozen", bad, 32'd0);
    check("gap_no_ready", bad_rdy, 32'd0);

    // Underrun: u held, clear, coincident clear+set
    wait_ready();
    din_valid = 1'b0;
    din = 16'h1234;
    cyc();
    din_valid = 1'b1;
    din = 16'hC000;
    check("underrun_set", {31'd0, underrun}, 32'd1);
    check("underrun_u_held", {16'd0, dut.u}, 32'h4000);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    check("underrun_clr", {31'd0, underrun}, 32'd0);
    wait_ready();
    din_valid = 1'b0;
    clr_flags = 1'b1;
    cyc();
    din_valid = 1'b1;
    clr_flags = 1'b0;
    check("underrun_set_wins", {31'd0, underrun}, 32'd1);

    // Overflow recovery via backdoor on e1/e2
    do_reset();
    din = 16'hC000; order_sel = 1'b1; din_valid = 1'b1;
    repeat (4) cyc();
    force dut.e1 = 18'h1FFFF;
    force dut.e2 = 18'h1FFFF;
    #1;
    release dut.e1;
    release dut.e2;
    cyc();
    check("ovf_set", {31'd0, ovf}, 32'd1);
    check("ovf_dout", {31'd0, dout}, 32'd1);
    check("ovf_e1_zero", {14'd0, dut.e1}, 32'd0);
    check("ovf_e2_zero", {14'd0, dut.e2}, 32'd0);
    clr_flags = 1'b1;
    cyc();
    clr_flags = 1'b0;
    count_ones(1024, ones);
    check("ovf_recover_ones", {31'd0, (ones >= 766 && ones <= 770)}, 32'd1);
    check("ovf_recover_flag", {31'd0, ovf}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
